// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: bundles the core request/response and data-memory signals of the unit
// slave  - unit side: takes requests and memory read data, drives responses and memory controls
// master - environment side (core + memory): the mirror image of slave
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_mask;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_mask, mem_wr_en, mem_rd_en
  );
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_mask, mem_wr_en, mem_rd_en
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between a core and a LATENCY-cycle data memory
// clk   - rising-edge clock
// reset - asynchronous, active-low
// bus   - mem_access_unit_if.slave: request (req_*), response (resp_*), memory (mem_*) signals
module mem_access_unit #(
  parameter int LATENCY = 1
) (
  input logic clk,
  input logic reset,
  mem_access_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic we;
  logic legal;
  // byte always legal; half needs addr[0]=0; word needs addr[1:0]=0; unsigned forms are load-only
  assign legal = (bus.req_funct3 == 3'b000) ||
                 (bus.req_funct3 == 3'b001 && !bus.req_addr[0]) ||
                 (bus.req_funct3 == 3'b010 && bus.req_addr[1:0] == 2'b00) ||
                 (!bus.req_we && (bus.req_funct3 == 3'b100 ||
                                  (bus.req_funct3 == 3'b101 && !bus.req_addr[0])));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      we             <= 1'b0;
      bus.req_ready  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.mem_mask   <= '0;
      bus.mem_wr_en  <= 1'b0;
      bus.mem_rd_en  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            we            <= bus.req_we;
            if (legal) begin
              state         <= ACCESS;
              cnt           <= 4'(LATENCY - 1);
              bus.mem_addr  <= bus.req_addr;
              bus.mem_wdata <= bus.req_wdata;
              bus.mem_mask  <= bus.req_funct3;
              bus.mem_wr_en <= bus.req_we;
              bus.mem_rd_en <= !bus.req_we;
            end else begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end
          end
        end
        ACCESS: begin
          // stores finish after one cycle; loads once the down-counter has run out
          if (we || cnt == 4'd0) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= we ? 32'd0 : bus.mem_rdata;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.mem_mask   <= '0;
            bus.mem_wr_en  <= 1'b0;
            bus.mem_rd_en  <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          // req_ready rises together with the return to IDLE, so no request shares this edge
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            bus.req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit with LATENCY=1 and LATENCY=3 instances
module tb_mem_access_unit;
  typedef struct {logic [31:0] rdata; logic err;} exp_t;
  logic clk = 1'b0;
  logic reset;
  logic sel3;
  logic req_valid, req_we, resp_ready;
  logic [2:0] req_funct3;
  logic [31:0] req_addr, req_wdata, mem_rdata;
  logic req_ready, resp_valid, resp_err, mem_wr_en, mem_rd_en;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [2:0] mem_mask;
  int tests = 0;
  int fails = 0;
  int rd_seen = 0;
  int wr_seen = 0;
  logic [31:0] last_addr, last_wdata, prev_rdata;
  logic [2:0] last_mask;
  logic prev_valid = 1'b0;
  logic prev_err = 1'b0;
  logic prev_hs = 1'b0;
  exp_t q[$];
  always #5 clk = ~clk;
  mem_access_unit_if b1 ();
  mem_access_unit_if b3 ();
  mem_access_unit #(.LATENCY(1)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));
  mem_access_unit #(.LATENCY(3)) u3 (.clk(clk), .reset(reset), .bus(b3.slave));
  assign b1.req_valid  = req_valid & ~sel3;
  assign b3.req_valid  = req_valid & sel3;
  assign b1.req_we     = req_we;
  assign b3.req_we     = req_we;
  assign b1.req_funct3 = req_funct3;
  assign b3.req_funct3 = req_funct3;
  assign b1.req_addr   = req_addr;
  assign b3.req_addr   = req_addr;
  assign b1.req_wdata  = req_wdata;
  assign b3.req_wdata  = req_wdata;
  assign b1.resp_ready = resp_ready;
  assign b3.resp_ready = resp_ready;
  assign b1.mem_rdata  = mem_rdata;
  assign b3.mem_rdata  = mem_rdata;
  assign req_ready  = sel3 ? b3.req_ready  : b1.req_ready;
  assign resp_valid = sel3 ? b3.resp_valid : b1.resp_valid;
  assign resp_rdata = sel3 ? b3.resp_rdata : b1.resp_rdata;
  assign resp_err   = sel3 ? b3.resp_err   : b1.resp_err;
  assign mem_addr   = sel3 ? b3.mem_addr   : b1.mem_addr;
  assign mem_wdata  = sel3 ? b3.mem_wdata  : b1.mem_wdata;
  assign mem_mask   = sel3 ? b3.mem_mask   : b1.mem_mask;
  assign mem_wr_en  = sel3 ? b3.mem_wr_en  : b1.mem_wr_en;
  assign mem_rd_en  = sel3 ? b3.mem_rd_en  : b1.mem_rd_en;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask
  // monitor: memory-side bookkeeping, response stability and scoreboard pops
  always @(negedge clk) begin
    exp_t e;
    if (mem_rd_en || mem_wr_en) begin
      check("en_exclusive", {31'b0, mem_rd_en & mem_wr_en}, 32'd0);
      last_addr  <= mem_addr;
      last_wdata <= mem_wdata;
      last_mask  <= mem_mask;
    end else begin
      check("mem_idle_zero", mem_addr | mem_wdata | {29'b0, mem_mask}, 32'd0);
    end
    if (mem_rd_en) rd_seen <= rd_seen + 1;
    if (mem_wr_en) wr_seen <= wr_seen + 1;
    if (resp_valid && prev_valid && !prev_hs) begin
      check("resp_rdata_stable", resp_rdata, prev_rdata);
      check("resp_err_stable", {31'b0, resp_err}, {31'b0, prev_err});
    end
    if (resp_valid && resp_ready) begin
      check("sb_nonempty", {31'b0, q.size() != 0}, 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
      end
    end
    prev_valid <= resp_valid;
    prev_rdata <= resp_rdata;
    prev_err   <= resp_err;
    prev_hs    <= resp_valid & resp_ready;
  end
  // issues one request, pushes its expected response, then drains the response after 'stall' cycles
  task automatic do_req(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rmem,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_rd, input int exp_wr, input int exp_wait, input int stall);
    int n;
    int rd0;
    int wr0;
    mem_rdata = rmem;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    q.push_back('{exp_rdata, exp_err});
    rd0 = rd_seen;
    wr0 = wr_seen;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
    n = 0;
    while (!resp_valid && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'(exp_wait));
    repeat (stall) begin
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({name, "_valid_drop"}, {31'b0, resp_valid}, 32'd0);
    check({name, "_idle_ready"}, {31'b0, req_ready}, 32'd1);
    check({name, "_rd_cycles"}, 32'(rd_seen - rd0), 32'(exp_rd));
    check({name, "_wr_cycles"}, 32'(wr_seen - wr0), 32'(exp_wr));
    if (!exp_err) begin
      check({name, "_mem_addr"}, last_addr, addr);
      check({name, "_mem_mask"}, {29'b0, last_mask}, {29'b0, f3});
      if (we) check({name, "_mem_wdata"}, last_wdata, wdata);
    end
  endtask
  initial begin
    reset = 1'b0; sel3 = 1'b0; req_valid = 1'b0; req_we = 1'b0; resp_ready = 1'b0;
    req_funct3 = 3'b000; req_addr = 32'd0; req_wdata = 32'd0; mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_mem_en", {30'b0, mem_rd_en, mem_wr_en}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rel_req_ready", {31'b0, req_ready}, 32'd1);
    //     name    we    f3      addr          wdata         mem_rdata     exp_rdata     err   rd wr wait stall
    do_req("lw",   1'b0, 3'b010, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1, 0, 1, 0);
    do_req("sb",   1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 32'h1111_1111, 32'h0,        1'b0, 0, 1, 1, 0);
    do_req("lh_mis", 1'b0, 3'b001, 32'h0000_0021, 32'h0,      32'h2222_2222, 32'h0,        1'b1, 0, 0, 0, 0);
    do_req("sw_mis", 1'b1, 3'b010, 32'h0000_0022, 32'h1234_5678, 32'h0,      32'h0,        1'b1, 0, 0, 0, 0);
    do_req("sbu_ill", 1'b1, 3'b100, 32'h0000_0000, 32'h0000_0077, 32'h0,     32'h0,        1'b1, 0, 0, 0, 0);
    do_req("f011_ill", 1'b0, 3'b011, 32'h0000_0008, 32'h0,    32'h3333_3333, 32'h0,        1'b1, 0, 0, 0, 0);
    do_req("lhu",  1'b0, 3'b101, 32'h0000_0022, 32'h0,        32'h0000_BEEF, 32'h0000_BEEF, 1'b0, 1, 0, 1, 2);
    do_req("sh",   1'b1, 3'b001, 32'h0000_0032, 32'h0000_C0DE, 32'h0,        32'h0,        1'b0, 0, 1, 1, 1);
    sel3 = 1'b1;
    @(posedge clk); #1;
    do_req("lbu3", 1'b0, 3'b100, 32'h0000_0040, 32'h0,        32'h0000_00EF, 32'h0000_00EF, 1'b0, 3, 0, 3, 4);
    // abort a LATENCY=3 load with reset in its second ACCESS cycle
    mem_rdata = 32'hAAAA_5555;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0080;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_rd_c1", {31'b0, mem_rd_en}, 32'd1);
    @(posedge clk); #1;
    check("abort_rd_c2", {31'b0, mem_rd_en}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort_rd_drop", {31'b0, mem_rd_en}, 32'd0);
    check("abort_req_ready", {31'b0, req_ready}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_no_resp", {31'b0, resp_valid}, 32'd0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_rel_ready", {31'b0, req_ready}, 32'd1);
    do_req("lw3",  1'b0, 3'b010, 32'h0000_0044, 32'h0,        32'h1234_5678, 32'h1234_5678, 1'b0, 3, 0, 3, 0);
    do_req("sw3",  1'b1, 3'b010, 32'h0000_0048, 32'hCAFE_F00D, 32'h0,        32'h0,        1'b0, 0, 1, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter LATENCY, default 1: memory read cycles per load, legal range 1..15.
REQ-002 SHALL have one clock and async active-low reset; ports are clk then reset:
  clk  input  1  rising-edge clock for all state
  reset  input  1  asynchronous, active-low (0 = in reset)
  req_valid  input  1  core request valid
  req_ready  output  1  unit can accept a request
  req_we  input  1  1 = store, 0 = load
  req_funct3  input  3  access type: 000 b, 001 h, 010 w, 100 bu, 101 hu
  req_addr  input  32  byte address
  req_wdata  input  32  store data, right-aligned
  resp_valid  output  1  response valid
  resp_ready  input  1  core accepts response
  resp_rdata  output  32  load result, extended per funct3
  resp_err  output  1  misaligned or illegal access, no memory access made
  mem_addr  output  32  byte address to data memory
  mem_wdata  output  32  store data to memory
  mem_mask  output  3  access type to memory
  mem_wr_en  output  1  memory write enable
  mem_rd_en  output  1  memory read enable
  mem_rdata  input  32  combinational memory read data, already extended

Function
REQ-003 FSM states SHALL be IDLE, ACCESS, RESP only.
REQ-004 req_ready SHALL be 1 in IDLE only; handshake on req_valid && req_ready at rising clk edge.
REQ-005 On handshake, addr, wdata, funct3 and we SHALL be latched; later req_* changes SHALL be ignored until IDLE.
REQ-006 Legal loads: funct3 000/100 any addr; 001/101 need addr[0]=0; 010 needs addr[1:0]=00.
REQ-007 Legal stores: funct3 000, 001, 010 with the same alignment rules; store with 100/101 is illegal.
REQ-008 funct3 011, 110, 111 SHALL be illegal for both loads and stores.
REQ-009 Illegal or misaligned request: IDLE -> RESP next edge, resp_err=1, resp_rdata=0, no mem_rd_en/mem_wr_en pulse.
REQ-010 Legal request: IDLE -> ACCESS; mem_addr, mem_wdata, mem_mask SHALL be driven from latched values for the whole ACCESS state.
REQ-011 Store: mem_wr_en=1 for exactly one ACCESS cycle, then RESP; resp_rdata=0, resp_err=0.
REQ-012 Load: mem_rd_en=1 for exactly LATENCY cycles; 4-bit down-counter loaded with LATENCY-1 on entry.
REQ-013 Load: mem_rdata SHALL be captured into resp_rdata at the rising edge ending the last ACCESS cycle (counter = 0), then RESP.
REQ-014 Outside ACCESS, mem_rd_en, mem_wr_en SHALL be 0; mem_addr, mem_wdata, mem_mask SHALL be 0.
REQ-015 RESP: resp_valid=1; resp_rdata, resp_err held stable until resp_valid && resp_ready.
REQ-016 On response handshake: -> IDLE; resp_valid drops next cycle; no new request accepted in the same cycle.
REQ-017 Minimum turnaround: store 3 cycles, load LATENCY+2 cycles, error 2 cycles (req to IDLE again, resp_ready=1).
REQ-018 mem_rd_en and mem_wr_en SHALL never be 1 in the same cycle.

Reset
REQ-019 reset=0 SHALL asynchronously force IDLE, counter 0, all outputs 0 except req_ready.
REQ-020 req_ready SHALL be 0 while reset=0 and 1 from the first edge after release.
REQ-021 Reset during ACCESS SHALL drop mem_rd_en/mem_wr_en immediately; no response for the aborted request.

Verification
REQ-022 LW addr 0x10, LATENCY=1, mem_rdata=0xDEADBEEF -> one mem_rd_en cycle, mem_mask=010, resp_rdata=0xDEADBEEF, resp_err=0.
REQ-023 SB addr 0x13, wdata 0x000000A5 -> single mem_wr_en cycle, mem_addr=0x13, mem_mask=000, mem_wdata=0xA5, resp_err=0.
REQ-024 LH addr 0x21 and SW addr 0x22 -> resp_err=1, resp_rdata=0, zero memory enables.
REQ-025 LATENCY=3, LBU addr 0x40, resp_ready held 0 for 4 cycles -> mem_rd_en exactly 3 cycles; resp_valid held with stable data until resp_ready=1.
REQ-026 reset=0 in 2nd ACCESS cycle of LATENCY=3 load -> mem_rd_en=0 immediately, no resp_valid; new LW after release completes normally.
